// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rst_seq_pkg
// Description : Shared types, default constants and the counter-width helper
//               for the power-up / reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rst_seq_pkg;

  // Sequencer states. The encoding is visible on the state_o debug port.
  typedef enum logic [1:0] {
    ST_WAIT_LOCK  = 2'd0,
    ST_REL_PERIPH = 2'd1,
    ST_REL_CORE   = 2'd2,
    ST_RUN        = 2'd3
  } rst_seq_state_e;

  localparam int c_lock_stable_cycles_def  = 64;
  localparam int c_stage_delay_cycles_def  = 16;
  localparam int c_lock_timeout_cycles_def = 65536;

  // The shared cycle counter must hold values up to the larger of the
  // lock-filter length and the stage delay.
  function automatic int seq_cnt_width(input int lock_cycles, input int stage_cycles);
    int max_cycles;
    max_cycles = (lock_cycles > stage_cycles) ? lock_cycles : stage_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit two-flop synchroniser with synchronous,
//               active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back captures give the first flop a full cycle to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rst_sequencer
// Description : Filters PLL lock and releases peripheral, core and
//               start-sequence resets in a staggered order. Re-sequences on
//               lock loss or a software reset request.
//               Optional lock-timeout flag enabled by the macro
//               RST_SEQ_LOCK_TIMEOUT_EN (lock_timeout tied to 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES  = c_lock_stable_cycles_def,
  parameter int STAGE_DELAY_CYCLES  = c_stage_delay_cycles_def,
  parameter int LOCK_TIMEOUT_CYCLES = c_lock_timeout_cycles_def
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       periph_reset_n,
  output logic       core_reset_n,
  output logic       seq_reset_n,
  output logic       sys_ready,
  output logic       lock_lost,
  output logic       lock_timeout,
  output logic [1:0] state_o
);

  localparam int c_cnt_w = seq_cnt_width(LOCK_STABLE_CYCLES, STAGE_DELAY_CYCLES);
  localparam logic [c_cnt_w-1:0] c_lock_last  = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_stage_last = c_cnt_w'(STAGE_DELAY_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  logic lock_s;

  rst_seq_state_e       state_q, state_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 lock_lost_q, lock_lost_d;
  logic                 periph_q, periph_d;
  logic                 core_q, core_d;
  logic                 seq_q, seq_d;
  logic                 ready_q, ready_d;

  // pll_locked is asynchronous to clk; only the synchronised copy is used.
  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d_i (pll_locked),
    .q_o (lock_s)
  );

  // State, counter and registered output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      lock_lost_q <= 1'b0;
      periph_q    <= 1'b0;
      core_q      <= 1'b0;
      seq_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_lost_q <= lock_lost_d;
      periph_q    <= periph_d;
      core_q      <= core_d;
      seq_q       <= seq_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state logic: lock filter, stage timing and abort handling. Outputs
  // decode the next state so each release lands on the transition edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_lost_d = lock_lost_q;

    case (state_q)
      ST_WAIT_LOCK: begin
        // Any low sample restarts the stability window.
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == c_lock_last) begin
          state_d = ST_REL_PERIPH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      ST_REL_PERIPH, ST_REL_CORE, ST_RUN: begin
        // Lock loss outranks a software request, so a coincident pair is
        // recorded as lock loss.
        if (!lock_s) begin
          state_d     = ST_WAIT_LOCK;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end else if (sw_reset_req) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (state_q != ST_RUN) begin
          if (cnt_q == c_stage_last) begin
            state_d = (state_q == ST_REL_PERIPH) ? ST_REL_CORE : ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_cnt_one;
          end
        end
      end
    endcase

    periph_d = (state_d != ST_WAIT_LOCK);
    core_d   = (state_d == ST_REL_CORE) || (state_d == ST_RUN);
    seq_d    = (state_d == ST_RUN);
    ready_d  = (state_d == ST_RUN);
  end

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  localparam int c_to_w = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [c_to_w-1:0] c_to_max  = c_to_w'(LOCK_TIMEOUT_CYCLES);
  localparam logic [c_to_w-1:0] c_to_one  = c_to_w'(1);

  logic [c_to_w-1:0] to_cnt_q, to_cnt_d;
  logic              timeout_q, timeout_d;

  // Time spent waiting for lock; saturates so the flag cannot re-trigger.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if ((state_q == ST_WAIT_LOCK) && (state_d == ST_WAIT_LOCK)) begin
      if (to_cnt_q == c_to_last) begin
        timeout_d = 1'b1;
      end
      if (to_cnt_q != c_to_max) begin
        to_cnt_d = to_cnt_q + c_to_one;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Timeout counter and sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign lock_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (LOCK_TIMEOUT_CYCLES != 0);
  assign lock_timeout       = 1'b0;
`endif

  assign periph_reset_n = periph_q;
  assign core_reset_n   = core_q;
  assign seq_reset_n    = seq_q;
  assign sys_ready      = ready_q;
  assign lock_lost      = lock_lost_q;
  assign state_o        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rst_sequencer
// Description : Self-checking bench for rst_sequencer with a timeline-based
//               reference model (elapsed edges since release).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_sequencer;

  localparam int L = 8;
  localparam int S = 4;
  localparam int T = 100;

`ifdef RST_SEQ_LOCK_TIMEOUT_EN
  localparam logic c_to_on = 1'b1;
`else
  localparam logic c_to_on = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       pll_locked;
  logic       sw_reset_req;
  logic       periph_reset_n;
  logic       core_reset_n;
  logic       seq_reset_n;
  logic       sys_ready;
  logic       lock_lost;
  logic       lock_timeout;
  logic [1:0] state_o;
  logic [7:0] obs;

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;

  // Reference model: in_seq means a release has happened and no abort since;
  // trel is the edge of the peripheral release.
  bit m_s1, m_s2, m_in_seq, m_lost, m_to;
  int m_stable, m_trel, m_wait;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rst_sequencer #(
    .LOCK_STABLE_CYCLES  (L),
    .STAGE_DELAY_CYCLES  (S),
    .LOCK_TIMEOUT_CYCLES (T)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pll_locked     (pll_locked),
    .sw_reset_req   (sw_reset_req),
    .periph_reset_n (periph_reset_n),
    .core_reset_n   (core_reset_n),
    .seq_reset_n    (seq_reset_n),
    .sys_ready      (sys_ready),
    .lock_lost      (lock_lost),
    .lock_timeout   (lock_timeout),
    .state_o        (state_o)
  );

  assign obs = {periph_reset_n, core_reset_n, seq_reset_n, sys_ready,
                lock_lost, lock_timeout, state_o};

  function automatic logic [7:0] exp_vec();
    int el;
    logic p, c, r, t;
    logic [1:0] st;
    el = edge_n - m_trel;
    p  = m_in_seq;
    c  = m_in_seq && (el >= S);
    r  = m_in_seq && (el >= 2 * S);
    t  = c_to_on & m_to;
    st = {1'b0, p} + {1'b0, c} + {1'b0, r};
    return {p, c, r, r, m_lost, t, st};
  endfunction

  task automatic model_edge();
    bit ls, was_wait;
    edge_n++;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_in_seq = 0; m_lost = 0; m_to = 0;
      m_stable = 0; m_wait = 0;
      return;
    end
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_locked;
    was_wait = !m_in_seq;
    if (m_in_seq) begin
      if (!ls) begin
        m_in_seq = 0;
        m_lost   = 1;
      end else if (sw_reset_req) begin
        m_in_seq = 0;
      end
      m_stable = 0;
    end else if (ls) begin
      m_stable++;
      if (m_stable == L) begin
        m_in_seq = 1;
        m_trel   = edge_n;
        m_stable = 0;
      end
    end else begin
      m_stable = 0;
    end
    if (was_wait && !m_in_seq) begin
      m_wait++;
      if (m_wait >= T) m_to = 1;
    end else begin
      m_wait = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b1; sw_reset_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_values: got %b expected %b", obs, 8'h00);
    end
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_model: got %b expected %b", obs, exp_vec());
    end
    sw_reset_req = 1'b0;
  endtask

  task automatic test_sequence();
    int k, rp, rc, rr;
    reset = 1'b1; pll_locked = 1'b0; tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    pll_locked = 1'b1;
    tick();
    k = edge_n;
    rp = -1; rc = -1; rr = -1;
    for (int i = 0; i < L + 2 * S + 6; i++) begin
      tick();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL seq_cycle edge %0d: got %b expected %b", edge_n, obs, exp_vec());
      end
      if (periph_reset_n && rp < 0) rp = edge_n;
      if (core_reset_n && rc < 0) rc = edge_n;
      if (sys_ready && rr < 0) rr = edge_n;
    end
    vectors++;
    if (rp !== k + 1 + L) begin
      miscompares++;
      $display("FAIL seq_periph_edge: got %0d expected %0d", rp - k, 1 + L);
    end
    vectors++;
    if (rc !== k + 1 + L + S) begin
      miscompares++;
      $display("FAIL seq_core_edge: got %0d expected %0d", rc - k, 1 + L + S);
    end
    vectors++;
    if (rr !== k + 1 + L + 2 * S) begin
      miscompares++;
      $display("FAIL seq_ready_edge: got %0d expected %0d", rr - k, 1 + L + 2 * S);
    end
  endtask

  task automatic test_glitch();
    int k, rp;
    reset = 1'b1; pll_locked = 1'b0; tick();
    reset = 1'b0;
    pll_locked = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    pll_locked = 1'b0; tick();
    pll_locked = 1'b1; tick();
    k  = edge_n;
    rp = -1;
    for (int i = 0; i < L + 2 * S + 6; i++) begin
      tick();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL glitch_cycle edge %0d: got %b expected %b", edge_n, obs, exp_vec());
      end
      if (periph_reset_n && rp < 0) rp = edge_n;
    end
    vectors++;
    if (rp !== k + 1 + L) begin
      miscompares++;
      $display("FAIL glitch_periph_edge: got %0d expected %0d", rp - k, 1 + L);
    end
    vectors++;
    if (lock_lost !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_lock_lost: got %b expected 0", lock_lost);
    end
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    tick(); tick();
    vectors++;
    if (periph_reset_n !== 1'b1) begin
      miscompares++;
      $display("FAIL loss_latency_early: got %b expected 1", periph_reset_n);
    end
    tick();
    vectors++;
    if (obs[7:3] !== 5'b00001) begin
      miscompares++;
      $display("FAIL loss_drop: got %b expected 00001", obs[7:3]);
    end
    pll_locked = 1'b1;
    for (int i = 0; i < L + 2 * S + 6; i++) begin
      tick();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL relock_cycle edge %0d: got %b expected %b", edge_n, obs, exp_vec());
      end
    end
    vectors++;
    if ({sys_ready, lock_lost} !== 2'b11) begin
      miscompares++;
      $display("FAIL relock_final: got %b expected 11", {sys_ready, lock_lost});
    end
  endtask

  task automatic test_sw_reset();
    int j, rp;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < L + 2 * S + 6; i++) tick();
    sw_reset_req = 1'b1;
    tick();
    j = edge_n;
    sw_reset_req = 1'b0;
    vectors++;
    if (obs[7:3] !== 5'b00000) begin
      miscompares++;
      $display("FAIL swreq_drop: got %b expected 00000", obs[7:3]);
    end
    rp = -1;
    for (int i = 0; i < L + 2 * S + 4; i++) begin
      tick();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL swreq_cycle edge %0d: got %b expected %b", edge_n, obs, exp_vec());
      end
      if (periph_reset_n && rp < 0) rp = edge_n;
    end
    vectors++;
    if (rp !== j + L) begin
      miscompares++;
      $display("FAIL swreq_periph_edge: got %0d expected %0d", rp - j, L);
    end
  endtask

  task automatic test_reset_mid();
    // Walk into REL_CORE, then hit reset.
    sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_in_seq && (edge_n - m_trel) == S + 1) break;
      tick();
    end
    vectors++;
    if (state_o !== 2'd2) begin
      miscompares++;
      $display("FAIL mid_pre_state: got %0d expected 2", state_o);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset: got %b expected %b", obs, 8'h00);
    end
    for (int i = 0; i < L + 2 * S + 6; i++) tick();
    // Lock low reaches the FSM two edges later; request lands on that edge.
    pll_locked = 1'b0; tick(); tick();
    sw_reset_req = 1'b1; tick(); sw_reset_req = 1'b0;
    vectors++;
    if (obs[7:3] !== 5'b00001) begin
      miscompares++;
      $display("FAIL coincident_abort: got %b expected 00001", obs[7:3]);
    end
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL coincident_model: got %b expected %b", obs, exp_vec());
    end
    pll_locked = 1'b1;
  endtask

  task automatic test_random();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
      sw_reset_req = ($urandom_range(0, 59) == 0);
      reset        = ($urandom_range(0, 399) == 0);
      tick();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_cycle edge %0d: got %b expected %b", edge_n, obs, exp_vec());
      end
    end
    reset = 1'b0; sw_reset_req = 1'b0;
  endtask

  task automatic test_timeout();
    reset = 1'b1; pll_locked = 1'b0; tick(); reset = 1'b0;
    for (int i = 0; i < T - 1; i++) tick();
    vectors++;
    if (lock_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got %b expected 0", lock_timeout);
    end
    tick();
    vectors++;
    if (lock_timeout !== c_to_on) begin
      miscompares++;
      $display("FAIL timeout_set: got %b expected %b", lock_timeout, c_to_on);
    end
    pll_locked = 1'b1;
    for (int i = 0; i < L + 2 * S + 6; i++) tick();
    vectors++;
    if ({sys_ready, lock_timeout} !== {1'b1, c_to_on}) begin
      miscompares++;
      $display("FAIL timeout_after_release: got %b expected %b",
               {sys_ready, lock_timeout}, {1'b1, c_to_on});
    end
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b0; sw_reset_req = 1'b0;
    test_reset();
    test_sequence();
    test_glitch();
    test_lock_loss();
    test_sw_reset();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
